// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: walks an m x n x k tile job for a MAC array.
// k is the innermost loop, then n, then m. Each issue is followed by
// PIPESTAGES wait cycles. A finished D tile is then held until the
// consumer accepts it.
// Optional build macro: MATMUL_SEQ_PERF_CNT_EN adds saturating busy and
// stall cycle counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no job; start with nonzero counts launches one
// S_ISSUE | one-cycle operand issue for (mi,ni,ki)
// S_WAIT  | waiting out the MAC pipeline latency
// S_OUT   | D tile (mi,ni) offered; held until out_ready
// S_DONE  | one-cycle done pulse, then back to idle
module matmul_tile_sequencer #(
   parameter int PIPESTAGES = 2,
   parameter int TW         = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [TW-1:0] cfg_m_tiles,
   input  logic [TW-1:0] cfg_n_tiles,
   input  logic [TW-1:0] cfg_k_tiles,
   output logic          busy,
   output logic          issue,
   output logic [TW-1:0] mi,
   output logic [TW-1:0] ni,
   output logic [TW-1:0] ki,
   output logic          acc_clear,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          done
`ifdef MATMUL_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]   perf_busy_cycles,
   output logic [31:0]   perf_stall_cycles
`endif
);

   localparam int CW = (PIPESTAGES > 1) ? $clog2(PIPESTAGES) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = (PIPESTAGES > 0) ? CW'(PIPESTAGES - 1) : '0;
   localparam bit NO_WAIT = (PIPESTAGES == 0);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] m_tiles, n_tiles, k_tiles;
   logic [CW-1:0] wait_cnt;
   logic          cfg_zero, last_k, last_n, last_m, wait_expired;

   assign cfg_zero     = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) || (cfg_k_tiles == '0);
   assign last_k       = (ki == k_tiles - TW'(1));
   assign last_n       = (ni == n_tiles - TW'(1));
   assign last_m       = (mi == m_tiles - TW'(1));
   assign wait_expired = (wait_cnt == '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      issue     = 1'b0;
      acc_clear = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = cfg_zero ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            issue     = 1'b1;
            acc_clear = (ki == '0);
            if (!NO_WAIT)    state_nxt = S_WAIT;
            else if (last_k) state_nxt = S_OUT;
            else             state_nxt = S_ISSUE;
         end
         S_WAIT: begin
            if (wait_expired) state_nxt = last_k ? S_OUT : S_ISSUE;
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = (last_m && last_n) ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Latched job counts, tile indices and latency down-counter
   always_ff @(posedge clk) begin
      if (rst) begin
         m_tiles  <= '0;
         n_tiles  <= '0;
         k_tiles  <= '0;
         mi       <= '0;
         ni       <= '0;
         ki       <= '0;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  m_tiles <= cfg_m_tiles;
                  n_tiles <= cfg_n_tiles;
                  k_tiles <= cfg_k_tiles;
                  mi      <= '0;
                  ni      <= '0;
                  ki      <= '0;
               end
            end
            S_ISSUE: begin
               if (!NO_WAIT)    wait_cnt <= WAIT_LOAD;
               else if (!last_k) ki      <= ki + TW'(1);
            end
            S_WAIT: begin
               if (!wait_expired) wait_cnt <= wait_cnt - CW'(1);
               else if (!last_k)  ki       <= ki + TW'(1);
            end
            S_OUT: begin
               if (out_ready) begin
                  ki <= '0;
                  if (last_n) begin
                     ni <= '0;
                     // Final tile: park indices at zero rather than past the limit.
                     mi <= last_m ? '0 : mi + TW'(1);
                  end else begin
                     ni <= ni + TW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MATMUL_SEQ_PERF_CNT_EN
   // Saturating busy/stall counters, cleared by reset or a new job
   always_ff @(posedge clk) begin
      if (rst || (state == S_IDLE && start)) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (busy && !(&perf_busy_cycles))
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
         if (state == S_OUT && !out_ready && !(&perf_stall_cycles))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule
